// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the data-memory arbiter, its two requesters and the memory.
// The master view is the arbiter; the slave view is everything around it.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              pipe_MemRead;
   logic              pipe_MemWrite;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_wr_data;
   logic [DATA_W-1:0] pipe_rd_data;
   logic              pipe_stall;

   logic              dbg_valid;
   logic              dbg_ready;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_rvalid;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      input  pipe_MemRead, pipe_MemWrite, pipe_addr, pipe_wr_data,
      output pipe_rd_data, pipe_stall,
      input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rdata, dbg_rvalid,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      output pipe_MemRead, pipe_MemWrite, pipe_addr, pipe_wr_data,
      input  pipe_rd_data, pipe_stall,
      output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rdata, dbg_rvalid,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline MEM stage has priority, the debug port
// is guaranteed a grant after STARVE_MAX consecutive pipeline grants while it waits.
module dmem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic            clk,
   input  logic            rst,
   dmem_arbiter_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_A = 2'd1,
      BUSY_B = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              dbg_rvalid_q;

   logic pipe_req;
   logic sel_b;
   logic grant_a;
   logic grant_b;
   logic done_a;
   logic done_b;

   assign pipe_req = bus.pipe_MemRead | bus.pipe_MemWrite;
   assign sel_b    = bus.dbg_valid & (~pipe_req | (cnt == CNT_MAX));
   assign done_a   = (state == BUSY_A) & bus.mem_ack;
   assign done_b   = (state == BUSY_B) & bus.mem_ack;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      grant_a = 1'b0;
      grant_b = 1'b0;
      unique case (state)
         IDLE: begin
            // Grants are suppressed while reset is held so nothing is accepted and lost.
            if (!rst) begin
               if (sel_b) begin
                  grant_b = 1'b1;
                  state_n = BUSY_B;
               end else if (pipe_req) begin
                  grant_a = 1'b1;
                  state_n = BUSY_A;
               end
            end
         end
         BUSY_A:  if (bus.mem_ack) state_n = IDLE;
         BUSY_B:  if (bus.mem_ack) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (grant_b) begin
         lat_we    <= bus.dbg_we;
         lat_addr  <= bus.dbg_addr;
         lat_wdata <= bus.dbg_wdata;
      end else if (grant_a) begin
         lat_we    <= bus.pipe_MemWrite;
         lat_addr  <= bus.pipe_addr;
         lat_wdata <= bus.pipe_wr_data;
      end
   end

   // Starvation counter: counts pipeline grants taken over a waiting debug request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (grant_b) begin
         cnt <= '0;
      end else if (grant_a && bus.dbg_valid) begin
         if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if ((state == IDLE) && !bus.dbg_valid) begin
         cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_rdata_q  <= '0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         dbg_rvalid_q <= done_b;
         if (done_b && !lat_we) dbg_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_req      = (state != IDLE);
   assign bus.mem_we       = lat_we;
   assign bus.mem_addr     = lat_addr;
   assign bus.mem_wdata    = lat_wdata;

   assign bus.pipe_stall   = pipe_req & ~done_a;
   assign bus.pipe_rd_data = done_a ? bus.mem_rdata : '0;

   assign bus.dbg_ready    = grant_b;
   assign bus.dbg_rdata    = dbg_rdata_q;
   assign bus.dbg_rvalid   = dbg_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a variable-latency memory model.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model: ack arrives 'lat' cycles after mem_req rises (0 = same cycle).
   logic [31:0] mem [256];
   int          lat = 0;
   int          wcnt;
   logic        load = 1'b0;
   logic [7:0]  load_idx = '0;
   logic [31:0] load_val = '0;

   assign bus.mem_ack   = bus.mem_req && (wcnt == lat);
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

   always @(posedge clk or posedge rst) begin
      if (rst) wcnt <= 0;
      else if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   always @(posedge clk) begin
      if (load) mem[load_idx] <= load_val;
      else if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      load = 1'b1; load_idx = addr[9:2]; load_val = val;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   // Presents one pipeline access and holds it while stalled; returns what was seen.
   task automatic pipe_op(input logic rd_en, input logic wr_en, input logic [31:0] a,
                          input logic [31:0] d, output int stalls, output logic [31:0] rd,
                          output logic we_ack, output logic addr_ok);
      bus.pipe_MemRead = rd_en; bus.pipe_MemWrite = wr_en;
      bus.pipe_addr = a; bus.pipe_wr_data = d;
      stalls = 0; rd = '0; we_ack = 1'b0; addr_ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         #1;
         if (bus.mem_req && bus.mem_addr !== a) addr_ok = 1'b0;
         if (!bus.pipe_stall) begin
            rd = bus.pipe_rd_data; we_ack = bus.mem_we;
            break;
         end
         stalls++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.pipe_MemRead = 1'b0; bus.pipe_MemWrite = 1'b0;
   endtask

   int          stalls, ready_cnt, stall_cnt, rv_cnt, nacks;
   logic [31:0] rd;
   logic        we_ack, addr_ok, drop_dbg, drop_pipe, rv_seen;
   logic [31:0] acks [8];

   initial begin
      bus.pipe_MemRead = 0; bus.pipe_MemWrite = 0; bus.pipe_addr = '0; bus.pipe_wr_data = '0;
      bus.dbg_valid = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      preload(32'h10, 32'hDEADBEEF);
      preload(32'h14, 32'hCAFE0014);
      preload(32'h20, 32'h0);
      preload(32'h40, 32'hA5A5A5A5);
      preload(32'h48, 32'h13572468);

      // Reset state with both requesters active
      bus.pipe_MemRead = 1; bus.dbg_valid = 1;
      #1;
      chk("rst_stall_with_req", bus.pipe_stall, 1);
      chk("rst_dbg_ready", bus.dbg_ready, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_dbg_rdata", bus.dbg_rdata, 0);
      chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
      chk("rst_cnt", dut.cnt, 0);
      bus.pipe_MemRead = 0; bus.dbg_valid = 0;
      #1;
      chk("rst_stall_no_req", bus.pipe_stall, 0);
      @(posedge clk); #1;
      rst = 0;

      // Latency 0 load
      lat = 0;
      pipe_op(1, 0, 32'h10, 32'h0, stalls, rd, we_ack, addr_ok);
      chk("lat0_stall", stalls, 1);
      chk("lat0_rd_data", rd, 32'hDEADBEEF);
      chk("lat0_we", we_ack, 0);

      // Latency 3 store
      lat = 3;
      pipe_op(0, 1, 32'h20, 32'h12345678, stalls, rd, we_ack, addr_ok);
      chk("lat3_stall", stalls, 4);
      chk("lat3_we", we_ack, 1);
      chk("lat3_addr_stable", addr_ok, 1);
      chk("lat3_mem_word", mem[8'h08], 32'h12345678);

      // Both MemRead and MemWrite: write wins
      lat = 1;
      pipe_op(1, 1, 32'h24, 32'h0BADF00D, stalls, rd, we_ack, addr_ok);
      chk("both_stall", stalls, 2);
      chk("both_we", we_ack, 1);
      chk("both_mem_word", mem[8'h09], 32'h0BADF00D);

      // Debug read with no pipeline traffic
      lat = 1;
      bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h40;
      ready_cnt = 0; stall_cnt = 0; rv_cnt = 0; drop_dbg = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (bus.dbg_ready) begin ready_cnt++; drop_dbg = 1; end
         if (bus.pipe_stall) stall_cnt++;
         if (bus.dbg_rvalid) rv_cnt++;
         @(posedge clk); #1;
         if (drop_dbg) begin bus.dbg_valid = 0; drop_dbg = 0; end
      end
      chk("dbg_ready_cycles", ready_cnt, 1);
      chk("dbg_no_stall", stall_cnt, 0);
      chk("dbg_rvalid_pulse", rv_cnt, 1);
      chk("dbg_rdata", bus.dbg_rdata, 32'hA5A5A5A5);

      // Starvation: continuous pipe loads while debug waits
      lat = 0;
      bus.pipe_addr = 32'h10; bus.pipe_MemRead = 1;
      bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h40;
      nacks = 0; ready_cnt = 0; rv_cnt = 0; drop_dbg = 0;
      for (int i = 0; i < 14; i++) begin
         #1;
         if (bus.dbg_ready) begin ready_cnt++; drop_dbg = 1; end
         if (bus.dbg_rvalid) rv_cnt++;
         if (bus.mem_req && bus.mem_ack && nacks < 8) begin acks[nacks] = bus.mem_addr; nacks++; end
         @(posedge clk); #1;
         if (drop_dbg) begin
            bus.dbg_valid = 0; drop_dbg = 0;
            chk("starve_cnt_cleared", dut.cnt, 0);
         end
      end
      bus.pipe_MemRead = 0;
      chk("starve_nacks", nacks, 7);
      for (int k = 0; k < 6; k++)
         chk($sformatf("starve_order_%0d", k), acks[k], (k == 4) ? 32'h40 : 32'h10);
      chk("starve_ready", ready_cnt, 1);
      chk("starve_rvalid", rv_cnt, 1);

      // Simultaneous requests with cnt=0: pipeline first, debug write afterwards
      lat = 2;
      @(posedge clk); #1;
      chk("simul_cnt_start", dut.cnt, 0);
      bus.pipe_addr = 32'h14; bus.pipe_MemRead = 1;
      bus.dbg_valid = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h44; bus.dbg_wdata = 32'h000055AA;
      nacks = 0; rv_cnt = 0; drop_dbg = 0; drop_pipe = 0; rd = '0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (i == 0) chk("simul_first_ready", bus.dbg_ready, 0);
         if (bus.dbg_ready) drop_dbg = 1;
         if (bus.dbg_rvalid) rv_cnt++;
         if (bus.pipe_MemRead && !bus.pipe_stall) begin drop_pipe = 1; rd = bus.pipe_rd_data; end
         if (bus.mem_req && bus.mem_ack && nacks < 8) begin acks[nacks] = bus.mem_addr; nacks++; end
         @(posedge clk); #1;
         if (drop_dbg) begin bus.dbg_valid = 0; bus.dbg_we = 0; drop_dbg = 0; end
         if (drop_pipe) begin bus.pipe_MemRead = 0; drop_pipe = 0; end
      end
      chk("simul_nacks", nacks, 2);
      chk("simul_first_pipe", acks[0], 32'h14);
      chk("simul_then_dbg", acks[1], 32'h44);
      chk("simul_pipe_rd", rd, 32'hCAFE0014);
      chk("simul_rvalid", rv_cnt, 1);
      chk("simul_mem_word", mem[8'h11], 32'h000055AA);
      chk("simul_rdata_held", bus.dbg_rdata, 32'hA5A5A5A5);

      // Reset during a latency-5 debug read
      lat = 5;
      bus.dbg_valid = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h48;
      #1;
      chk("rstmid_accept", bus.dbg_ready, 1);
      @(posedge clk); #1;
      bus.dbg_valid = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("rstmid_busy", bus.mem_req, 1);
      rst = 1;
      bus.dbg_valid = 1;
      #1;
      chk("rstmid_req_drop", bus.mem_req, 0);
      chk("rstmid_state", dut.state, 0);
      chk("rstmid_no_ready", bus.dbg_ready, 0);
      rv_seen = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if (bus.dbg_rvalid) rv_seen = 1;
      end
      rst = 0;
      #1;
      chk("rstmid_no_rvalid", rv_seen, 0);
      chk("rstmid_reaccept", bus.dbg_ready, 1);
      @(posedge clk); #1;
      bus.dbg_valid = 0;
      rv_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.dbg_rvalid) begin rv_seen = 1; break; end
         @(posedge clk); #1;
      end
      chk("rstmid_retry_done", rv_seen, 1);
      chk("rstmid_retry_rdata", bus.dbg_rdata, 32'h13572468);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
